// File: rtl/term_encoder_if.sv
// Operand/result handshake bundle between the term encoder and its neighbours.
// The master side drives operands and consumes results; the slave side is the encoder.
interface term_encoder_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_COMBINED_TERMS = 8,
    parameter int NUM_BIT_EXPONENT   = 3
);
    logic                                         in_valid;
    logic                                         in_ready;
    logic [DATA_WIDTH-1:0]                        in_data;
    logic [3:0]                                   term_budget;
    logic [NUM_BIT_EXPONENT*NUM_COMBINED_TERMS-1:0] out_exponent;
    logic [NUM_COMBINED_TERMS-1:0]                out_sign;
    logic [3:0]                                   out_terms;
    logic [DATA_WIDTH-1:0]                        out_residual;
    logic                                         out_valid;
    logic                                         out_ready;
    logic                                         start_shift;

    modport master (
        output in_valid, in_data, term_budget, out_ready,
        input  in_ready, out_exponent, out_sign, out_terms, out_residual,
               out_valid, start_shift
    );

    modport slave (
        input  in_valid, in_data, term_budget, out_ready,
        output in_ready, out_exponent, out_sign, out_terms, out_residual,
               out_valid, start_shift
    );
endinterface

// File: rtl/term_encoder.sv
// Breaks a signed operand into up to term_budget signed power-of-two terms, MSB first,
// one bit per cycle, and holds the packed result until the MAC takes it.
module term_encoder #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_COMBINED_TERMS = 8,
    parameter int NUM_BIT_EXPONENT   = 3
) (
    input  logic             clk,
    input  logic             reset,
    term_encoder_if.slave    bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int EXP_W = NUM_BIT_EXPONENT * NUM_COMBINED_TERMS;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [3:0]                    count_q, count_d;
    logic [3:0]                    budget_q, budget_d;
    logic                          neg_q, neg_d;
    logic [DATA_WIDTH-1:0]         residual_q, residual_d;
    logic [EXP_W-1:0]              exp_q, exp_d;
    logic [NUM_COMBINED_TERMS-1:0] sgn_q, sgn_d;

    logic [DATA_WIDTH-1:0] magnitude;
    logic [DATA_WIDTH-1:0] low_mask;
    logic                  low_zero;
    logic [3:0]            count_next;
    logic [3:0]            budget_clamped;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            budget_q   <= '0;
            neg_q      <= 1'b0;
            residual_q <= '0;
            exp_q      <= '0;
            sgn_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            budget_q   <= budget_d;
            neg_q      <= neg_d;
            residual_q <= residual_d;
            exp_q      <= exp_d;
            sgn_q      <= sgn_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        budget_d   = budget_q;
        neg_d      = neg_q;
        residual_d = residual_q;
        exp_d      = exp_q;
        sgn_d      = sgn_q;
        count_next = count_q;

        // The most negative operand negates back to itself, which read unsigned is its magnitude.
        magnitude      = bus.in_data[DATA_WIDTH-1] ? (~bus.in_data + DATA_WIDTH'(1)) : bus.in_data;
        budget_clamped = (int'(bus.term_budget) > NUM_COMBINED_TERMS) ?
                         4'(NUM_COMBINED_TERMS) : bus.term_budget;
        low_mask       = (DATA_WIDTH'(1) << idx_q) - DATA_WIDTH'(1);
        low_zero       = ((residual_q & low_mask) == '0);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    residual_d = magnitude;
                    neg_d      = bus.in_data[DATA_WIDTH-1];
                    budget_d   = budget_clamped;
                    exp_d      = '0;
                    sgn_d      = '0;
                    count_d    = '0;
                    idx_d      = IDX_W'(DATA_WIDTH - 1);
                    state_d    = (budget_clamped == 4'd0) ? HOLD : SCAN;
                end
            end
            SCAN: begin
                if (residual_q[idx_q]) begin
                    for (int k = 0; k < NUM_COMBINED_TERMS; k++) begin
                        if (count_q == 4'(k)) begin
                            exp_d[k*NUM_BIT_EXPONENT +: NUM_BIT_EXPONENT] = NUM_BIT_EXPONENT'(idx_q);
                            sgn_d[k] = neg_q;
                        end
                    end
                    residual_d[idx_q] = 1'b0;
                    count_next        = count_q + 4'd1;
                end
                count_d = count_next;
                // Bits below idx are untouched this cycle, so residual_q decides early exit.
                if ((idx_q == '0) || (count_next == budget_q) || low_zero) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.start_shift  = bus.out_valid & bus.out_ready;
    assign bus.out_exponent = exp_q;
    assign bus.out_sign     = sgn_q;
    assign bus.out_terms    = count_q;
    assign bus.out_residual = residual_q;
endmodule

// File: tb/tb_term_encoder.sv
// Scoreboard bench for term_encoder: the driver queues hand-computed results,
// a negedge monitor pops and compares them at every output handshake.
module tb_term_encoder;
    logic clk;
    logic reset;
    int   cyc;
    int   compared;
    int   mismatched;

    typedef struct {
        logic [23:0] exponent;
        logic [7:0]  sign;
        logic [3:0]  terms;
        logic [7:0]  residual;
        int          latency;
        int          accept_cycle;
    } expect_t;

    expect_t sb[$];

    bit          valid_seen;
    int          valid_start;
    logic [23:0] held_exponent;
    logic [7:0]  held_sign;
    logic [3:0]  held_terms;
    logic [7:0]  held_residual;

    term_encoder_if #(.DATA_WIDTH(8), .NUM_COMBINED_TERMS(8), .NUM_BIT_EXPONENT(3)) bus ();

    term_encoder #(.DATA_WIDTH(8), .NUM_COMBINED_TERMS(8), .NUM_BIT_EXPONENT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Results are compared at the negedge where out_valid & out_ready, i.e. just before the handshake edge.
    always @(negedge clk) begin
        if (reset) begin
            valid_seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!valid_seen) begin
                valid_seen    = 1'b1;
                valid_start   = cyc;
                held_exponent = bus.out_exponent;
                held_sign     = bus.out_sign;
                held_terms    = bus.out_terms;
                held_residual = bus.out_residual;
            end else begin
                checkOutput("stable_exponent", 32'(bus.out_exponent), 32'(held_exponent));
                checkOutput("stable_residual", 32'(bus.out_residual), 32'(held_residual));
            end
            if (bus.out_ready) begin
                expect_t item;
                checkOutput("start_shift_pulse", 32'(bus.start_shift), 32'd1);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 32'd1, 32'd0);
                end else begin
                    item = sb.pop_front();
                    checkOutput("out_exponent", 32'(bus.out_exponent), 32'(item.exponent));
                    checkOutput("out_sign",     32'(bus.out_sign),     32'(item.sign));
                    checkOutput("out_terms",    32'(bus.out_terms),    32'(item.terms));
                    checkOutput("out_residual", 32'(bus.out_residual), 32'(item.residual));
                    checkOutput("latency",      32'(valid_start - item.accept_cycle), 32'(item.latency));
                end
                valid_seen = 1'b0;
            end else begin
                checkOutput("stall_start_shift", 32'(bus.start_shift), 32'd0);
                checkOutput("stall_in_ready",    32'(bus.in_ready),    32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] budget,
                                 input logic [23:0] e_exp, input logic [7:0] e_sign,
                                 input logic [3:0] e_terms, input logic [7:0] e_res,
                                 input int e_lat, input bit do_push, input int extra_hold);
        int wait_cnt;
        expect_t item;
        wait_cnt = 0;
        while (!bus.in_ready && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.in_valid    = 1'b1;
        bus.in_data     = data;
        bus.term_budget = budget;
        item.exponent     = e_exp;
        item.sign         = e_sign;
        item.terms        = e_terms;
        item.residual     = e_res;
        item.latency      = e_lat;
        item.accept_cycle = cyc;
        if (do_push) sb.push_back(item);
        @(posedge clk); #1;
        // A second operand offered while busy must be ignored.
        bus.in_data     = 8'd99;
        bus.term_budget = 4'd1;
        repeat (extra_hold) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || bus.out_valid) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        compared        = 0;
        mismatched      = 0;
        valid_seen      = 1'b0;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.term_budget = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("reset_out_valid",    32'(bus.out_valid),    32'd0);
        checkOutput("reset_start_shift",  32'(bus.start_shift),  32'd0);
        checkOutput("reset_out_exponent", 32'(bus.out_exponent), 32'd0);
        checkOutput("reset_out_sign",     32'(bus.out_sign),     32'd0);
        checkOutput("reset_out_terms",    32'(bus.out_terms),    32'd0);
        checkOutput("reset_out_residual", 32'(bus.out_residual), 32'd0);
        checkOutput("reset_in_ready",     32'(bus.in_ready),     32'd1);

        applyStimulus(8'd45,   4'd8,  24'h00009D, 8'h00, 4'd4, 8'd0,  9, 1'b1, 3);
        applyStimulus(8'hD3,   4'd2,  24'h00001D, 8'h03, 4'd2, 8'd5,  6, 1'b1, 0);
        applyStimulus(8'h80,   4'd8,  24'h000007, 8'h01, 4'd1, 8'd0,  2, 1'b1, 0);
        applyStimulus(8'd0,    4'd5,  24'h000000, 8'h00, 4'd0, 8'd0,  2, 1'b1, 0);
        applyStimulus(8'd45,   4'd0,  24'h000000, 8'h00, 4'd0, 8'd45, 1, 1'b1, 0);
        applyStimulus(8'd101,  4'd3,  24'h0000AE, 8'h00, 4'd3, 8'd1,  7, 1'b1, 0);
        applyStimulus(8'd127,  4'd15, 24'h00A72E, 8'h00, 4'd7, 8'd0,  9, 1'b1, 0);
        drain();

        // Backpressure: result must sit unchanged while the MAC is not ready.
        bus.out_ready = 1'b0;
        applyStimulus(8'hD3, 4'd2, 24'h00001D, 8'h03, 4'd2, 8'd5, 6, 1'b1, 0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a scan discards the operand.
        applyStimulus(8'd45, 4'd8, 24'h0, 8'h0, 4'd0, 8'd0, 0, 1'b0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("midreset_out_valid",    32'(bus.out_valid),    32'd0);
        checkOutput("midreset_in_ready",     32'(bus.in_ready),     32'd1);
        checkOutput("midreset_out_terms",    32'(bus.out_terms),    32'd0);
        checkOutput("midreset_out_residual", 32'(bus.out_residual), 32'd0);
        applyStimulus(8'hD3, 4'd2, 24'h00001D, 8'h03, 4'd2, 8'd5, 6, 1'b1, 0);
        drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/term_encoder.md
TERM_ENCODER -- requirements
Module: term_encoder

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: width of the signed input operand.
REQ-002 SHALL provide parameter NUM_COMBINED_TERMS, default 8: number of term slots per output word.
REQ-003 SHALL provide parameter NUM_BIT_EXPONENT, default 3: width of each exponent field.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have in_valid, input, 1: operand present.
REQ-007 SHALL have in_ready, output, 1: encoder accepts an operand.
REQ-008 SHALL have in_data, input, DATA_WIDTH: signed two's-complement operand.
REQ-009 SHALL have term_budget, input, 4: maximum terms to emit; sampled on accept.
REQ-010 SHALL have out_exponent, output, NUM_BIT_EXPONENT*NUM_COMBINED_TERMS: packed exponents; slot k at bits [k*NUM_BIT_EXPONENT +: NUM_BIT_EXPONENT].
REQ-011 SHALL have out_sign, output, NUM_COMBINED_TERMS: per-slot sign, 1 = negative.
REQ-012 SHALL have out_terms, output, 4: number of valid slots, driven to the MAC data_terms input.
REQ-013 SHALL have out_residual, output, DATA_WIDTH: unencoded magnitude dropped by truncation.
REQ-014 SHALL have out_valid, output, 1, and out_ready, input, 1: output handshake.
REQ-015 SHALL have start_shift, output, 1: load strobe to the MAC input registers.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, HOLD; in_ready = (state==IDLE), combinational.
REQ-017 Accept = in_valid & in_ready: latch magnitude = |in_data| as unsigned DATA_WIDTH (-128 gives 128), sign = in_data MSB, budget = min(term_budget, NUM_COMBINED_TERMS); clear slots, count, bit index = DATA_WIDTH-1.
REQ-018 On accept: budget 0 -> HOLD with zero terms and residual = magnitude; otherwise -> SCAN.
REQ-019 SCAN processes exactly one bit index per cycle, MSB first; a set bit writes exponent = index and sign into slot[count], then count increments, and the bit is cleared from the residual.
REQ-020 SCAN -> HOLD after the current cycle when index==0, count_next==budget, or all residual bits below index are zero; otherwise index decrements.
REQ-021 Slots at and above out_terms SHALL read zero in exponent and sign.
REQ-022 HOLD: out_valid=1; outputs SHALL stay stable until out_ready=1; on handshake -> IDLE, out_valid falls next cycle.
REQ-023 start_shift = out_valid & out_ready, combinational, one pulse per result.
REQ-024 Latency: out_valid asserts the cycle after the last SCAN cycle; for budget 0 it asserts the cycle after accept; worst case DATA_WIDTH+1 cycles.
REQ-025 Emitted terms SHALL satisfy magnitude = sum of 2^exp + out_residual.
REQ-026 Only one operand in flight; in_valid outside IDLE SHALL be ignored.

Reset
REQ-027 Reset SHALL force IDLE and clear all latched state; reset asserted in SCAN or HOLD SHALL discard the in-flight operand.
REQ-028 After reset, outputs SHALL be: out_valid=0, start_shift=0, out_exponent=0, out_sign=0, out_terms=0, out_residual=0, in_ready=1.

Verification
REQ-029 Operand 45 with budget 8, accepted at T -> out_valid at T+9; out_exponent=24'h00009D (slots 5,3,2,0); out_sign=0; out_terms=4; out_residual=0.
REQ-030 Operand -45 with budget 2 -> out_valid at T+6; slots {5,3}; out_sign=8'b00000011; out_terms=2; out_residual=5.
REQ-031 Operand -128 with budget 8 -> out_valid at T+2; slot0=7; out_sign=8'b00000001; out_terms=1; out_residual=0. Operand 0 with budget 5 -> out_valid at T+2, all fields 0.
REQ-032 Operand 45 with budget 0 -> out_valid at T+1; out_terms=0; out_residual=45.
REQ-033 Backpressure: out_ready held 0 for 3 cycles in HOLD -> outputs stable, in_ready=0, start_shift=0; out_ready=1 -> single start_shift pulse, then in_ready=1 next cycle.
REQ-034 Reset pulsed in SCAN -> next cycle IDLE, out_valid=0, in_ready=1; the following operand encodes correctly.
